// File: rtl/pe_ctrl_sequencer.sv
// Program-memory sequencer for a PE: loads control words over a valid/ready
// config port, then replays them one per cycle for loop_cnt+1 passes.
module pe_ctrl_sequencer #(
  parameter int                    CTRL_WIDTH = 11,
  parameter int                    DEPTH      = 16,
  parameter logic [CTRL_WIDTH-1:0] NOP_WORD   = '0,
  parameter int                    ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CTRL_WIDTH-1:0] cfg_data,
  input  logic                  cfg_last,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            loop_cnt,
  output logic [CTRL_WIDTH-1:0] ctrl,
  output logic                  ctrl_valid,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] pc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CTRL_WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   last_q, last_d;
  logic                    loaded_q, loaded_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [7:0]              iter_q, iter_d;
  logic [7:0]              loop_q, loop_d;
  logic [CTRL_WIDTH-1:0]   ctrl_q, ctrl_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    beat;
  logic                    mem_we;

  assign cfg_ready  = (state_q == IDLE);
  assign busy       = (state_q == RUN);
  assign beat       = cfg_valid && cfg_ready;
  assign ctrl       = ctrl_q;
  assign ctrl_valid = valid_q;
  assign done       = done_q;
  assign pc         = pc_q;

  // The program length is kept as the index of the final word, so the
  // end-of-pass test is a plain equality against pc.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    last_d   = last_q;
    loaded_d = loaded_q;
    pc_d     = pc_q;
    iter_d   = iter_q;
    loop_d   = loop_q;
    ctrl_d   = ctrl_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    mem_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (beat) begin
          mem_we   = 1'b1;
          loaded_d = 1'b0;
          if (cfg_last || (wr_ptr_q == ADDR_WIDTH'(DEPTH - 1))) begin
            last_d   = wr_ptr_q;
            loaded_d = 1'b1;
            wr_ptr_d = '0;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end else if (start && loaded_q) begin
          state_d = RUN;
          pc_d    = '0;
          iter_d  = '0;
          loop_d  = loop_cnt;
          ctrl_d  = mem[0];
          valid_d = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          ctrl_d  = NOP_WORD;
          valid_d = 1'b0;
          pc_d    = '0;
        end else if (pc_q != last_q) begin
          pc_d   = pc_q + 1'b1;
          ctrl_d = mem[pc_q + 1'b1];
        end else if (iter_q != loop_q) begin
          pc_d   = '0;
          iter_d = iter_q + 8'd1;
          ctrl_d = mem[0];
        end else begin
          state_d = DONE;
          ctrl_d  = NOP_WORD;
          valid_d = 1'b0;
          done_d  = 1'b1;
          pc_d    = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        ctrl_d  = NOP_WORD;
        valid_d = 1'b0;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      last_q   <= '0;
      loaded_q <= 1'b0;
      pc_q     <= '0;
      iter_q   <= '0;
      loop_q   <= '0;
      ctrl_q   <= NOP_WORD;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      last_q   <= last_d;
      loaded_q <= loaded_d;
      pc_q     <= pc_d;
      iter_q   <= iter_d;
      loop_q   <= loop_d;
      ctrl_q   <= ctrl_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  // Program storage is deliberately not reset; prog_loaded gates its use.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= cfg_data;
    end
  end

endmodule
